// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
//   Shared constants and types for the instruction-fetch front end.
//   ACC_WORD      : mainMem access-size code for a single 32-bit word.
//   INSN_BYTES    : PC increment between sequential fetches.
//   fetch_entry_t : one prefetch-queue entry at the default widths. The top
//                   packs {pc, insn} into its queue in this same order.
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam logic [1:0] ACC_WORD     = 2'b00;
    localparam int         INSN_BYTES   = 4;
    localparam int         FETCH_ADDR_W = 32;
    localparam int         FETCH_DATA_W = 32;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] insn;
    } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
//   DEPTH x WIDTH synchronous FIFO used as the prefetch queue.
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset (pointers and count)
//   push_i       : write push_data_i at the tail
//   push_data_i  : entry to write
//   pop_i        : drop the head entry (ignored when empty)
//   flush_i      : empty the queue; wins over push and pop
//   head_o       : entry at the head (meaningful only when count_o != 0)
//   count_o      : number of stored entries, 0..DEPTH
// ----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != (PTR_W+1)'(DEPTH)) || do_pop);

    // NOTE: all state uses non-blocking assignments so every flop samples the
    // pre-edge values; combinational blocks use blocking assignments instead.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read after
    // it was written, and the top masks the head while the queue is empty.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule : fetch_fifo

// File: rtl/fetch_prefetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_prefetch_unit
//   Instruction-fetch front end between mainMem and decode. Issues sequential
//   word reads from a programmable PC, tracks outstanding reads in a
//   READ_LATENCY-deep pipe, buffers returned words with their PC in a
//   DEPTH-entry queue and hands them to decode with valid/ready. A redirect
//   flushes the queue and bumps an epoch bit so reads already in flight are
//   dropped when they return.
//   clock, reset_n            : clock and asynchronous active-low reset
//   fetch_enable              : allow new requests
//   redirect, redirect_pc     : one-cycle restart at a word-aligned PC
//   mem_addr/enable/wren/acc_size, mem_busy, mem_data_out : mainMem read port
//   insn, insn_pc, insn_valid, insn_ready                 : decode handshake
// ----------------------------------------------------------------------------
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W        = 32,
    parameter int                DATA_W        = 32,
    parameter logic [ADDR_W-1:0] START_ADDRESS = 32'h8002_0000,
    parameter int                DEPTH         = 4,
    parameter int                READ_LATENCY  = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              fetch_enable,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_enable,
    output logic              mem_wren,
    output logic [1:0]        mem_acc_size,
    input  logic              mem_busy,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic [DATA_W-1:0] insn,
    output logic [ADDR_W-1:0] insn_pc,
    output logic              insn_valid,
    input  logic              insn_ready
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int INF_W   = $clog2(READ_LATENCY + 1);
    localparam int ENTRY_W = ADDR_W + DATA_W;

    logic [ADDR_W-1:0]       fetch_pc_q;
    logic [ADDR_W-1:0]       fetch_pc_d;
    logic                    epoch_q;
    logic [READ_LATENCY-1:0] pipe_vld_q;
    logic [READ_LATENCY-1:0] pipe_ep_q;
    logic [ADDR_W-1:0]       pipe_pc_q [READ_LATENCY];
    logic [INF_W-1:0]        inflight;
    logic [CNT_W-1:0]        q_count;
    logic                    may_issue;
    logic                    accept;
    logic                    ret_keep;
    logic [ENTRY_W-1:0]      head;

    // Outstanding reads, squashed ones included, so credit never over-commits the queue.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + INF_W'(pipe_vld_q[i]);
        end
    end

    // reset_n is folded in so the request drops the moment reset is asserted,
    // not at the next edge.
    assign may_issue = reset_n && fetch_enable && !redirect &&
                       ((32'(q_count) + 32'(inflight)) < 32'(DEPTH));
    assign accept    = may_issue && !mem_busy;

    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc & ~ADDR_W'(3);
        end else if (accept) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(INSN_BYTES);
        end
    end

    // Accepted reads shift toward the tail; stage 0 holds the newest request.
    // No accept can happen in a redirect cycle, so epoch_q is the right tag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q <= START_ADDRESS;
            epoch_q    <= 1'b0;
            pipe_vld_q <= '0;
            pipe_ep_q  <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pipe_pc_q[i] <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            if (redirect) epoch_q <= ~epoch_q;
            pipe_vld_q[0] <= accept;
            pipe_ep_q[0]  <= epoch_q;
            pipe_pc_q[0]  <= fetch_pc_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_ep_q[i]  <= pipe_ep_q[i-1];
                pipe_pc_q[i]  <= pipe_pc_q[i-1];
            end
        end
    end

    // A return is kept only if it belongs to the current epoch and no redirect
    // is flushing the queue this very cycle.
    assign ret_keep = pipe_vld_q[READ_LATENCY-1] &&
                      (pipe_ep_q[READ_LATENCY-1] == epoch_q) && !redirect;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i       (clock),
        .rst_ni      (reset_n),
        .push_i      (ret_keep),
        .push_data_i ({pipe_pc_q[READ_LATENCY-1], mem_data_out}),
        .pop_i       (insn_ready && !redirect),
        .flush_i     (redirect),
        .head_o      (head),
        .count_o     (q_count)
    );

    assign insn_valid           = (q_count != '0);
    assign {insn_pc, insn}      = insn_valid ? head : '0;
    assign mem_enable           = may_issue;
    assign mem_addr             = fetch_pc_q;
    assign mem_wren             = 1'b0;
    assign mem_acc_size         = ACC_WORD;

endmodule : fetch_prefetch_unit

// File: tb/tb_fetch_prefetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_prefetch_unit
//   Directed bench for fetch_prefetch_unit. Three instances share the stimulus:
//   u_dut (defaults), u_wrap (START_ADDRESS near the top of the address space)
//   and u_lat2 (READ_LATENCY=2, so reads are still in flight across a redirect).
//   mainMem is a preloaded 64-word array indexed by addr[7:2].
// ----------------------------------------------------------------------------
module tb_fetch_prefetch_unit;
    import fetch_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        fetch_enable;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_busy;
    logic        insn_ready;

    logic [31:0] mem_addr,   w_mem_addr,   l_mem_addr;
    logic        mem_enable, w_mem_enable, l_mem_enable;
    logic        mem_wren,   w_mem_wren,   l_mem_wren;
    logic [1:0]  mem_acc,    w_mem_acc,    l_mem_acc;
    logic [31:0] insn,       w_insn,       l_insn;
    logic [31:0] insn_pc,    w_insn_pc,    l_insn_pc;
    logic        insn_valid, w_insn_valid, l_insn_valid;

    logic [31:0] m_data  = 32'hDEAD_BEEF;
    logic [31:0] w_data  = 32'hDEAD_BEEF;
    logic [31:0] l_stage = 32'hDEAD_BEEF;
    logic [31:0] l_data  = 32'hDEAD_BEEF;

    logic [31:0] rom [64];
    int          n_run  = 0;
    int          n_fail = 0;
    logic        mon_en = 1'b0;
    logic [31:0] exp_pc = '0;
    int          acc;

    always #5 clock = ~clock;

    fetch_prefetch_unit u_dut (
        .clock(clock), .reset_n(reset_n), .fetch_enable(fetch_enable),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wren(mem_wren),
        .mem_acc_size(mem_acc), .mem_busy(mem_busy), .mem_data_out(m_data),
        .insn(insn), .insn_pc(insn_pc), .insn_valid(insn_valid), .insn_ready(insn_ready)
    );

    fetch_prefetch_unit #(.START_ADDRESS(32'hFFFF_FFF8)) u_wrap (
        .clock(clock), .reset_n(reset_n), .fetch_enable(fetch_enable),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_addr(w_mem_addr), .mem_enable(w_mem_enable), .mem_wren(w_mem_wren),
        .mem_acc_size(w_mem_acc), .mem_busy(mem_busy), .mem_data_out(w_data),
        .insn(w_insn), .insn_pc(w_insn_pc), .insn_valid(w_insn_valid), .insn_ready(insn_ready)
    );

    fetch_prefetch_unit #(.READ_LATENCY(2)) u_lat2 (
        .clock(clock), .reset_n(reset_n), .fetch_enable(fetch_enable),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_addr(l_mem_addr), .mem_enable(l_mem_enable), .mem_wren(l_mem_wren),
        .mem_acc_size(l_mem_acc), .mem_busy(mem_busy), .mem_data_out(l_data),
        .insn(l_insn), .insn_pc(l_insn_pc), .insn_valid(l_insn_valid), .insn_ready(insn_ready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return rom[a[7:2]];
    endfunction

    // mainMem models: data for an accepted request appears READ_LATENCY cycles later;
    // anything else on the bus is junk that must never be captured.
    always @(posedge clock) begin
        m_data  <= (mem_enable   && !mem_busy) ? mem_word(mem_addr)   : 32'hDEAD_BEEF;
        w_data  <= (w_mem_enable && !mem_busy) ? mem_word(w_mem_addr) : 32'hDEAD_BEEF;
        l_stage <= (l_mem_enable && !mem_busy) ? mem_word(l_mem_addr) : 32'hDEAD_BEEF;
        l_data  <= l_stage;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Move to the sampling point; if enabled, check every pop of u_dut against
    // the next expected sequential PC and its memory word.
    task automatic sample();
        @(negedge clock);
        if (mon_en && insn_valid && insn_ready) begin
            check("pop_pc", insn_pc, exp_pc);
            check("pop_insn", insn, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    // Move to just after the next rising edge, where inputs are changed.
    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic en, input logic rdy);
        reset_n      = 1'b0;
        mon_en       = 1'b0;
        fetch_enable = en;
        insn_ready   = rdy;
        mem_busy     = 1'b0;
        redirect     = 1'b0;
        next();
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = {16'hC0DE, 10'(i), 6'h13};
        reset_n      = 1'b0;
        fetch_enable = 1'b1;
        insn_ready   = 1'b1;
        redirect     = 1'b0;
        redirect_pc  = '0;
        mem_busy     = 1'b0;

        // Reset state, with enable and ready already high.
        next();
        sample();
        check("rst_valid",   32'(insn_valid), 32'd0);
        check("rst_mem_en",  32'(mem_enable), 32'd0);
        check("rst_addr",    mem_addr, 32'h8002_0000);
        check("rst_insn",    insn, 32'd0);
        check("rst_insn_pc", insn_pc, 32'd0);
        check("rst_wren",    32'(mem_wren), 32'd0);
        check("rst_acc",     32'(mem_acc), 32'd0);
        next();
        reset_n = 1'b1;

        // 1 Stream (and 5 wrap on u_wrap).
        mon_en = 1'b1;
        exp_pc = 32'h8002_0000;
        sample();
        check("t1_en_a",    32'(mem_enable), 32'd1);
        check("t1_addr_a",  mem_addr, 32'h8002_0000);
        check("t1_valid_a", 32'(insn_valid), 32'd0);
        next();
        sample();
        check("t1_addr_b",  mem_addr, 32'h8002_0004);
        check("t1_valid_b", 32'(insn_valid), 32'd0);
        next();
        for (int i = 0; i < 6; i++) begin
            sample();
            check("t1_valid", 32'(insn_valid), 32'd1);
            check("t1_addr",  mem_addr, 32'h8002_0008 + 32'(4 * i));
            check("t1_wren",  32'(mem_wren), 32'd0);
            if (i < 3) begin
                check("t5_wrap_pc",   w_insn_pc, 32'hFFFF_FFF8 + 32'(4 * i));
                check("t5_wrap_insn", w_insn, mem_word(32'hFFFF_FFF8 + 32'(4 * i)));
            end
            next();
        end
        check("t1_pop_count", exp_pc, 32'h8002_0018);

        // 6 Async reset between edges, mid-stream.
        mon_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_valid_now",  32'(insn_valid), 32'd0);
        check("t6_mem_en_now", 32'(mem_enable), 32'd0);
        check("t6_addr_now",   mem_addr, 32'h8002_0000);
        check("t6_pc_now",     insn_pc, 32'd0);
        sample();
        next();
        reset_n = 1'b1;
        mon_en  = 1'b1;
        exp_pc  = 32'h8002_0000;
        sample();
        check("t6_first_addr", mem_addr, 32'h8002_0000);
        check("t6_first_en",   32'(mem_enable), 32'd1);
        check("t6_no_late_0",  32'(insn_valid), 32'd0);
        next();
        sample();
        check("t6_no_late_1",  32'(insn_valid), 32'd0);
        next();
        sample();
        check("t6_first_pop",  exp_pc, 32'h8002_0004);
        next();

        // 2 Backpressure.
        do_reset(1'b1, 1'b0);
        mon_en = 1'b1;
        exp_pc = 32'h8002_0000;
        acc    = 0;
        for (int i = 0; i < 8; i++) begin
            sample();
            if (mem_enable && !mem_busy) acc++;
            next();
        end
        sample();
        check("t2_accepts",    32'(acc), 32'd4);
        check("t2_mem_en_off", 32'(mem_enable), 32'd0);
        check("t2_head_valid", 32'(insn_valid), 32'd1);
        check("t2_head_pc",    insn_pc, 32'h8002_0000);
        next();
        insn_ready = 1'b1;
        sample();
        check("t2_full_no_issue", 32'(mem_enable), 32'd0);
        next();
        sample();
        check("t2_resume_en",   32'(mem_enable), 32'd1);
        check("t2_resume_addr", mem_addr, 32'h8002_0010);
        next();
        for (int i = 0; i < 6; i++) begin
            sample();
            next();
        end
        check("t2_pops", exp_pc, 32'h8002_0020);

        // 3 Busy for 3 cycles at 80020008.
        do_reset(1'b1, 1'b1);
        mon_en = 1'b1;
        exp_pc = 32'h8002_0000;
        for (int i = 0; i < 2; i++) begin
            sample();
            next();
        end
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("t3_busy_addr", mem_addr, 32'h8002_0008);
            check("t3_busy_en",   32'(mem_enable), 32'd1);
            next();
        end
        mem_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sample();
            next();
        end
        check("t3_pops", exp_pc, 32'h8002_0018);

        // Redirect while busy: the held request is withdrawn.
        mon_en      = 1'b0;
        mem_busy    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h8002_0102;
        sample();
        check("t4b_withdraw", 32'(mem_enable), 32'd0);
        next();
        redirect = 1'b0;
        mem_busy = 1'b0;
        sample();
        check("t4b_flushed", 32'(insn_valid), 32'd0);
        check("t4b_addr",    mem_addr, 32'h8002_0100);
        check("t4b_en",      32'(mem_enable), 32'd1);
        next();
        mon_en = 1'b1;
        exp_pc = 32'h8002_0100;
        for (int i = 0; i < 4; i++) begin
            sample();
            next();
        end
        check("t4b_pops", exp_pc, 32'h8002_010C);

        // 4 Redirect to 80020043 with 2 reads in flight (u_lat2) and 2 queued.
        do_reset(1'b1, 1'b0);
        redirect_pc = 32'h8002_0043;
        for (int i = 0; i < 4; i++) begin
            sample();
            next();
        end
        redirect = 1'b1;
        sample();
        check("t4_redir_en",    32'(l_mem_enable), 32'd0);
        check("t4_queued",      32'(l_insn_valid), 32'd1);
        check("t4_queued_head", l_insn_pc, 32'h8002_0000);
        next();
        redirect = 1'b0;
        sample();
        check("t4_l2_flushed",  32'(l_insn_valid), 32'd0);
        check("t4_flushed",     32'(insn_valid), 32'd0);
        check("t4_new_addr",    mem_addr, 32'h8002_0040);
        check("t4_l2_new_addr", l_mem_addr, 32'h8002_0040);
        next();
        sample();
        check("t4_l2_stale_c6", 32'(l_insn_valid), 32'd0);
        next();
        sample();
        check("t4_l2_stale_c7", 32'(l_insn_valid), 32'd0);
        check("t4_first_pc",    insn_pc, 32'h8002_0040);
        next();
        insn_ready = 1'b1;
        sample();
        check("t4_l2_valid",    32'(l_insn_valid), 32'd1);
        check("t4_l2_first_pc", l_insn_pc, 32'h8002_0040);
        check("t4_l2_first_in", l_insn, mem_word(32'h8002_0040));
        next();
        sample();
        check("t4_l2_second_pc", l_insn_pc, 32'h8002_0044);
        check("t4_second_pc",    insn_pc, 32'h8002_0044);
        next();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule : tb_fetch_prefetch_unit
